// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, parallel load, shift, rotate and clear modes,
// plus a saturating shift counter and a done pulse after WIDTH shifts.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    count,
  output logic             done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             done_reg;
  logic             done_next;
  logic             is_shift;

  // Next-state selection; the reserved encoding falls through to hold.
  always_comb begin
    q_next     = q_reg;
    count_next = count_reg;
    is_shift   = 1'b0;
    case (mode_t'(mode))
      MODE_LOAD: begin
        q_next     = D;
        count_next = '0;
      end
      MODE_SHL: begin
        q_next   = {q_reg[WIDTH-2:0], sin_r};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {sin_l, q_reg[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_CLR: begin
        q_next     = '0;
        count_next = '0;
      end
      default: ;
    endcase
    if (is_shift && (count_reg != COUNT_MAX)) begin
      count_next = count_reg + CW'(1);
    end
    done_next = is_shift && (count_reg == COUNT_MAX - CW'(1));
  end

  // done only ever lasts one enabled edge; a disabled edge clears it too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg     <= RESET_VALUE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else if (en) begin
      q_reg     <= q_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end else begin
      done_reg  <= 1'b0;
    end
  end

  assign Q      = q_reg;
  assign Qbar   = ~q_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];
  assign count  = count_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=4, RESET_VALUE=1010): directed plan
// followed by randomized traffic, checked against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int W = 4;
  localparam int CWT = $clog2(W + 1);
  localparam logic [W-1:0] RV = 4'b1010;

  typedef struct {
    logic [W-1:0] q;
    int           cnt;
    logic         dn;
  } exp_t;

  logic           clock;
  logic           reset;
  logic           en;
  logic [2:0]     mode;
  logic [W-1:0]   D;
  logic           sin_l;
  logic           sin_r;
  logic [W-1:0]   Q;
  logic [W-1:0]   Qbar;
  logic           sout_l;
  logic           sout_r;
  logic [CWT-1:0] count;
  logic           done;

  bit   clock_run;
  exp_t sb_q[$];
  exp_t async_q[$];
  event async_probe;
  int   vectors;
  int   miscompares;

  int unsigned model_q;
  int          model_cnt;
  logic        model_done;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .D(D),
    .sin_l(sin_l), .sin_r(sin_r), .Q(Q), .Qbar(Qbar),
    .sout_l(sout_l), .sout_r(sout_r), .count(count), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever begin
      #5;
      if (clock_run) clock = ~clock;
    end
  end

  function automatic exp_t snapshot();
    exp_t e;
    e.q   = W'(model_q);
    e.cnt = model_cnt;
    e.dn  = model_done;
    return e;
  endfunction

  // Reference model: register as an integer, shifts as multiply/divide by two.
  task automatic model_step(input logic m_en, input logic [2:0] m_mode,
                            input logic [W-1:0] m_d, input logic m_sl, input logic m_sr);
    int unsigned mask;
    int unsigned top;
    bit          shifted;
    mask       = (1 << W) - 1;
    top        = 1 << (W - 1);
    shifted    = 0;
    model_done = 1'b0;
    if (m_en) begin
      case (m_mode)
        3'd1: begin model_q = m_d; model_cnt = 0; end
        3'd2: begin model_q = (model_q * 2 + m_sr) % (mask + 1); shifted = 1; end
        3'd3: begin model_q = model_q / 2 + (m_sl ? top : 0); shifted = 1; end
        3'd4: begin model_q = (model_q * 2) % (mask + 1) + model_q / top; shifted = 1; end
        3'd5: begin model_q = model_q / 2 + ((model_q % 2) * top); shifted = 1; end
        3'd6: begin model_q = 0; model_cnt = 0; end
        default: ;
      endcase
      if (shifted && model_cnt < W) begin
        model_cnt++;
        if (model_cnt == W) model_done = 1'b1;
      end
    end
  endtask

  task automatic apply_stimulus(input logic a_en, input logic [2:0] a_mode,
                                input logic [W-1:0] a_d, input logic a_sl, input logic a_sr);
    @(negedge clock);
    en    = a_en;
    mode  = a_mode;
    D     = a_d;
    sin_l = a_sl;
    sin_r = a_sr;
    model_step(a_en, a_mode, a_d, a_sl, a_sr);
    sb_q.push_back(snapshot());
  endtask

  // Asserts reset between edges, checks its immediate effect, then releases it.
  task automatic pulse_reset();
    @(negedge clock);
    en = 1'b0;
    #1 reset = 1'b1;
    model_q = RV; model_cnt = 0; model_done = 1'b0;
    #1;
    async_q.push_back(snapshot());
    ->async_probe;
    #1 reset = 1'b0;
    sb_q.push_back(snapshot());
  endtask

  task automatic check_output(input exp_t e, input string tag);
    bit bad;
    bad = 0;
    vectors++;
    if (Q !== e.q) begin
      $display("[TB] FAIL %s Q: got %b expected %b", tag, Q, e.q); bad = 1;
    end
    if (Qbar !== ~e.q) begin
      $display("[TB] FAIL %s Qbar: got %b expected %b", tag, Qbar, ~e.q); bad = 1;
    end
    if (sout_l !== e.q[W-1] || sout_r !== e.q[0]) begin
      $display("[TB] FAIL %s sout: got l=%b r=%b expected l=%b r=%b",
               tag, sout_l, sout_r, e.q[W-1], e.q[0]); bad = 1;
    end
    if (count !== CWT'(e.cnt)) begin
      $display("[TB] FAIL %s count: got %0d expected %0d", tag, count, e.cnt); bad = 1;
    end
    if (done !== e.dn) begin
      $display("[TB] FAIL %s done: got %b expected %b", tag, done, e.dn); bad = 1;
    end
    if (bad) miscompares++;
  endtask

  initial begin : monitor_clocked
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) check_output(sb_q.pop_front(), "edge");
    end
  end

  initial begin : monitor_async
    forever begin
      @(async_probe);
      if (async_q.size() > 0) check_output(async_q.pop_front(), "async_reset");
    end
  end

  initial begin : stimulus
    int budget;
    vectors = 0; miscompares = 0;
    clock_run = 0;
    reset = 1'b0; en = 1'b0; mode = 3'd0; D = '0; sin_l = 1'b0; sin_r = 1'b0;
    model_q = RV; model_cnt = 0; model_done = 1'b0;

    // Reset with the clock stopped must act immediately.
    #3 reset = 1'b1;
    #1;
    async_q.push_back(snapshot());
    ->async_probe;
    #2 reset = 1'b0;
    clock_run = 1;

    repeat (3) apply_stimulus(1, 3'd0, 4'b0110, 1, 1);

    apply_stimulus(1, 3'd1, 4'b1001, 0, 0);
    apply_stimulus(1, 3'd2, 4'b0000, 0, 1);
    apply_stimulus(1, 3'd2, 4'b0000, 1, 0);
    apply_stimulus(1, 3'd2, 4'b0000, 0, 1);
    apply_stimulus(1, 3'd2, 4'b0000, 0, 1);
    apply_stimulus(1, 3'd2, 4'b0000, 0, 0);

    apply_stimulus(1, 3'd1, 4'b0001, 0, 0);
    repeat (4) apply_stimulus(1, 3'd3, 4'b1111, 1, 0);

    apply_stimulus(1, 3'd1, 4'b1000, 0, 0);
    repeat (4) apply_stimulus(1, 3'd4, 4'b0000, 1, 1);
    apply_stimulus(1, 3'd5, 4'b0000, 1, 1);

    for (int i = 0; i < 3; i++) apply_stimulus(0, 3'd2, 4'b0101, 0, 1'(i));
    apply_stimulus(1, 3'd7, 4'b0101, 1, 1);
    apply_stimulus(1, 3'd6, 4'b0101, 1, 1);

    apply_stimulus(1, 3'd2, 4'b0000, 0, 1);
    apply_stimulus(1, 3'd2, 4'b0000, 0, 1);
    pulse_reset();
    repeat (4) apply_stimulus(1, 3'd2, 4'b0000, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else apply_stimulus($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                          W'($urandom), 1'($urandom), 1'($urandom));
    end

    budget = 0;
    while ((sb_q.size() > 0 || async_q.size() > 0) && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (sb_q.size() > 0 || async_q.size() > 0) begin
      $display("[TB] FAIL drain: got %0d pending expectations expected 0",
               sb_q.size() + async_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with synchronous enable, parallel load, shift, rotate and clear modes.
- Also maintains a saturating shift counter and a one-cycle done pulse after WIDTH shifts since the last load or clear.
- Serves as the generic storage and serialisation element for the digital-systems lab designs (serial converters, LFSR and test-pattern shells).

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, 0, value loaded into Q on reset; WIDTH bits, upper bits truncated.
- CW, $clog2(WIDTH+1), width of the count output. Derived localparam; not user-set.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  synchronous enable; when 0, all registered state holds.
- mode  input  3  operation select; see Behaviour.
- D  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB on a right shift.
- sin_r  input  1  serial input entering at the LSB on a left shift.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q.
- sout_l  output  1  Q[WIDTH-1]; combinational from Q.
- sout_r  output  1  Q[0]; combinational from Q.
- count  output  CW  shifts or rotates performed since the last load, clear or reset; saturates at WIDTH.
- done  output  1  registered one-cycle pulse.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset (asserted at any time, including mid-operation):
  - Q = RESET_VALUE, Qbar = ~RESET_VALUE.
  - count = 0, done = 0.
  - Takes effect immediately, independent of clock.
  - First update after deassertion occurs on the next rising edge.
- Qbar, sout_l and sout_r are always consistent with Q; no extra latency.
- All mode effects are visible one cycle after the edge that samples them (latency 1).
- en = 0: Q and count hold; done = 0 on that edge.
- Modes, applied when en = 1:
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q <= D; count <= 0.
  - 010 SHL: Q <= {Q[WIDTH-2:0], sin_r}.
  - 011 SHR: Q <= {sin_l, Q[WIDTH-1:1]}.
  - 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 ROR: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 110 CLR: Q <= 0 (not RESET_VALUE); count <= 0.
  - 111 reserved: behaves exactly as HOLD.
- Counter:
  - Each SHL/SHR/ROL/ROR edge with en = 1 increments count when count < WIDTH.
  - At count == WIDTH, further shifts leave count at WIDTH (saturation; no wrap).
- done:
  - Set to 1 for exactly one cycle on the edge where count transitions from WIDTH-1 to WIDTH.
  - 0 on every other edge, including further shifts while saturated.
- Serial inputs are ignored in all modes except SHL and SHR.
- D is ignored except in LOAD.
- Rotates WIDTH times restore the original Q.
- Simultaneous events: only one mode exists per cycle, so there is no priority conflict between modes. Reset dominates en and mode.

Test Plan (WIDTH=4, RESET_VALUE=4'b1010):
1. Assert reset with clock stopped -> Q=1010, Qbar=0101, count=0, done=0 immediately. Deassert, then HOLD 3 cycles -> Q stays 1010.
2. LOAD D=1001, then SHL with sin_r=1,0,1,1 -> Q sequence 0011, 0110, 1101, 1011. count=1,2,3,4. done=1 only in the cycle count becomes 4. 5th SHL -> count stays 4, done=0.
3. LOAD 0001, then SHR with sin_l=1 four times -> Q 1000, 1100, 1110, 1111. sout_r sequence before each edge is 1,0,0,0.
4. LOAD 1000, ROL x4 -> 0001, 0010, 0100, 1000 (original restored), done pulses once. Then ROR x1 -> 0100.
5. en=0 with mode=SHL and sin_r toggling for 3 cycles -> Q and count unchanged, done=0. Modes 111 and 110: 111 holds Q, 110 gives Q=0000, count=0.
6. Assert reset asynchronously between edges after 2 SHL (count=2) -> immediate Q=1010, count=0. After release, 4 SHL -> done pulses at the 4th shift.
